rr_arb64x4: RTL and testbench

//  Round-robin arbiter sharing one 64-bit 4:1 mux datapath among 4 requesters.

---
 rtl/rr_arb64x4.sv | 92 +++++++++
 tb/tb_rr_arb64x4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb64x4.sv
// Round-robin 4:1 arbiter over a shared 64-bit mux; grant one cycle after request, MAX_BURST beats per tenure.
// Backpressure holds grant, sel and beat count; a withdrawn request or a full burst releases via one idle cycle.
module rr_arb64x4 #(
  parameter int MAX_BURST = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [3:0]   req_i,
  input  logic [255:0] d_i,
  output logic [3:0]   ack_o,
  output logic [3:0]   grant_o,
  output logic [1:0]   sel_o,
  output logic [63:0]  out_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         busy_o
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      sel_q;
  logic [3:0]      grant_q;
  logic [CW-1:0]   beat_cnt_q;

  logic [1:0]      ptr_d;
  logic [1:0]      winner;
  logic [1:0]      idx;
  logic            found;
  logic            beat;
  logic            last_beat;

  // Scan ptr, ptr+1, ... with 2-bit wrap; the first requester seen wins.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign out_o       = d_i[{sel_q, 6'd0} +: 64];
  assign out_valid_o = ~reset_i & (state_q == BUSY) & req_i[sel_q];
  assign beat        = out_valid_o & out_ready_i;
  assign ack_o       = grant_q & {4{beat}};
  assign last_beat   = (beat_cnt_q == CW'(MAX_BURST - 1));
  assign ptr_d       = sel_q + 2'd1;
  assign grant_o     = grant_q;
  assign sel_o       = sel_q;
  assign busy_o      = (state_q == BUSY);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      sel_q      <= 2'd0;
      grant_q    <= 4'd0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q    <= 4'b0001 << winner;
            sel_q      <= winner;
            beat_cnt_q <= '0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          // Withdrawal or a completed burst both hand the pointer past the current owner.
          if (!req_i[sel_q] || (beat && last_beat)) begin
            grant_q <= 4'd0;
            state_q <= IDLE;
            ptr_q   <= ptr_d;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb64x4.sv
// Directed bench for rr_arb64x4: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_rr_arb64x4;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [255:0] d;
  logic [3:0]   ack;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic [63:0]  out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  typedef struct {
    logic [3:0]  g;
    logic [63:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [63:0] words [4];

  rr_arb64x4 #(.MAX_BURST(4)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .req_i      (req),
    .d_i        (d),
    .ack_o      (ack),
    .grant_o    (grant),
    .sel_o      (sel),
    .out_o      (out),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input int n);
    exp_t e;
    int   i;
    i = (g == 4'b0001) ? 0 : (g == 4'b0010) ? 1 : (g == 4'b0100) ? 2 : 3;
    e.g = g;
    e.w = words[i];
    for (int k = 0; k < n; k++) exp_q.push_back(e);
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {60'd0, ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_ack", {60'd0, ack}, {60'd0, e.g});
        chk("beat_grant", {60'd0, grant}, {60'd0, e.g});
        chk("beat_data", out, e.w);
      end
    end else begin
      chk("no_beat_ack", {60'd0, ack}, 64'd0);
    end
  end

  task automatic chk_idle(input string name);
    #1;
    chk({name, "_busy"}, {63'd0, busy}, 64'd0);
    chk({name, "_grant"}, {60'd0, grant}, 64'd0);
    chk({name, "_valid"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    words[0] = 64'h1111_0000_0000_0000;
    words[1] = 64'h2222_0000_0000_0001;
    words[2] = 64'hDEAD_BEEF_0000_0002;
    words[3] = 64'h4444_0000_0000_0003;
    d = {words[3], words[2], words[1], words[0]};
    reset = 1'b1;
    req = 4'b1111;
    out_ready = 1'b1;

    // 1: reset held two cycles with all requests up
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      chk("rst_grant", {60'd0, grant}, 64'd0);
      chk("rst_sel", {62'd0, sel}, 64'd0);
      chk("rst_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_ack", {60'd0, ack}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
    end

    // 2: single requester 2, two full bursts separated by one bubble
    reset = 1'b0;
    req = 4'b0100;
    push(4'b0100, 8);
    step();
    #1;
    chk("t2_grant", {60'd0, grant}, {60'd0, 4'b0100});
    chk("t2_sel", {62'd0, sel}, 64'd2);
    chk("t2_out", out, 64'hDEAD_BEEF_0000_0002);
    for (int c = 0; c < 3; c++) step();
    step();
    chk_idle("t2_bubble");
    step();
    #1;
    chk("t2_regrant", {60'd0, grant}, {60'd0, 4'b0100});
    for (int c = 0; c < 3; c++) step();
    step();
    req = 4'b0000;

    // 3: all requesting from ptr=0, rotation 0,1,2,3,0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) push(4'b0001 << (t % 4), 4);
    for (int t = 0; t < 5; t++) begin
      step();
      #1;
      chk("t3_grant", {60'd0, grant}, {60'd0, 4'b0001 << (t % 4)});
      for (int c = 0; c < 3; c++) step();
      step();
      if (t == 4) req = 4'b0000;
      chk_idle("t3_bubble");
    end

    // 4: requester 1 stalled three cycles mid-burst
    req = 4'b0010;
    push(4'b0010, 4);
    step();
    #1;
    chk("t4_grant", {60'd0, grant}, {60'd0, 4'b0010});
    step();
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t4_stall_valid", {63'd0, out_valid}, 64'd1);
      chk("t4_stall_ack", {60'd0, ack}, 64'd0);
      chk("t4_stall_sel", {62'd0, sel}, 64'd1);
      chk("t4_stall_out", out, words[1]);
      step();
    end
    out_ready = 1'b1;
    step();
    #1;
    chk("t4_last_busy", {63'd0, busy}, 64'd1);
    step();
    req = 4'b0000;
    chk_idle("t4_release");

    // 5: requester 1 withdraws after two beats, then 1011 skips 2 and grants 3
    req = 4'b0010;
    push(4'b0010, 2);
    step();
    step();
    step();
    req = 4'b0000;
    #1;
    chk("t5_drop_ack", {60'd0, ack}, 64'd0);
    chk("t5_drop_busy", {63'd0, busy}, 64'd1);
    step();
    chk_idle("t5_release");
    req = 4'b1011;
    push(4'b1000, 4);
    step();
    #1;
    chk("t5_grant", {60'd0, grant}, {60'd0, 4'b1000});
    chk("t5_sel", {62'd0, sel}, 64'd3);
    for (int c = 0; c < 3; c++) step();
    step();
    req = 4'b0000;

    // 6: reset in beat 2 of a burst, then all requesting grants 0 first
    req = 4'b0100;
    push(4'b0100, 2);
    step();
    step();
    step();
    reset = 1'b1;
    #1;
    chk("t6_rst_ack", {60'd0, ack}, 64'd0);
    chk("t6_rst_valid", {63'd0, out_valid}, 64'd0);
    step();
    #1;
    chk("t6_grant", {60'd0, grant}, 64'd0);
    chk("t6_sel", {62'd0, sel}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    req = 4'b1111;
    push(4'b0001, 4);
    step();
    #1;
    chk("t6_regrant", {60'd0, grant}, {60'd0, 4'b0001});
    for (int c = 0; c < 3; c++) step();
    step();
    req = 4'b0000;

    for (int c = 0; c < 3; c++) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
